// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, default
// bus widths and the wait-counter load helper.
package mem_responder_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter start value so that WAIT lasts exactly wc cycles.
  function automatic logic [3:0] wait_load(input int wc);
    logic [3:0] val_s;
    if (wc > 0) begin
      val_s = 4'(wc - 1);
    end else begin
      val_s = 4'd0;
    end
    return val_s;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Storage for the responder: DEPTH x DATA_W words, synchronous write and a
// registered read port. The array itself is deliberately not reset.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Write port: contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
  end

  // Read register: holds its value until the next successful read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[idx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one read or write at a time from the
// controller, inserts WAIT_CYCLES wait states, then pulses mem_ready.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_read,
  input  logic              MEM_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_A   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        WAIT_LOAD = wait_load(WAIT_CYCLES);

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              op_wr_r;
  logic              mem_ready_r;
  logic              busy_r;
  logic              err_r;

  logic              req_one_s;
  logic              req_both_s;
  logic              go_resp_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [DATA_W-1:0] acc_wdata_s;
  logic              acc_wr_s;
  logic              in_range_s;
  logic              mem_we_s;
  logic              mem_re_s;

  // Decide whether this edge enters RESP and which request it completes;
  // with zero wait states the live inputs are used because nothing is latched yet.
  always_comb begin
    req_one_s  = MEM_read ^ MEM_write;
    req_both_s = MEM_read & MEM_write;
    go_resp_s  = 1'b0;
    case (state_r)
      ST_IDLE: go_resp_s = req_one_s && (WAIT_CYCLES == 0);
      ST_WAIT: go_resp_s = (cnt_r == 4'd0);
      default: go_resp_s = 1'b0;
    endcase
    if (state_r == ST_IDLE) begin
      acc_addr_s  = addr;
      acc_wdata_s = wdata;
      acc_wr_s    = MEM_write;
    end else begin
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      acc_wr_s    = op_wr_r;
    end
    in_range_s = ({1'b0, acc_addr_s} < DEPTH_A);
    mem_we_s   = rst & go_resp_s & acc_wr_s & in_range_s;
    mem_re_s   = rst & go_resp_s & ~acc_wr_s & in_range_s;
  end

  // Request FSM with wait counter, request latches and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      op_wr_r     <= 1'b0;
      mem_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      mem_ready_r <= 1'b0;
      err_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_one_s) begin
            addr_r  <= addr;
            wdata_r <= wdata;
            op_wr_r <= MEM_write;
            busy_r  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_r     <= ST_RESP;
              mem_ready_r <= 1'b1;
              err_r       <= ~in_range_s;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_LOAD;
            end
          end else if (req_both_s) begin
            err_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (go_resp_s) begin
            state_r     <= ST_RESP;
            mem_ready_r <= 1'b1;
            err_r       <= ~in_range_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we_s),
    .re    (mem_re_s),
    .idx   (acc_addr_s[IDX_W-1:0]),
    .wdata (acc_wdata_s),
    .rdata (rdata)
  );

  assign mem_ready = mem_ready_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule
